seq_pattern_gen: RTL and testbench



---
 rtl/seq_pkg.sv | 13 +
 rtl/pattern_shift_reg.sv | 42 ++++
 rtl/seq_pattern_gen.sv | 133 +++++++++++++
 tb/tb_seq_pattern_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the pattern generator and the sequence detectors it drives.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0] DEF_PATTERN = 5'b11011;

endpackage

// File: rtl/pattern_shift_reg.sv
// PISO holding the stored pattern plus a working copy shifted out MSB-first.
// The serial output is registered and returns to 0 on any cycle with no bit to send.
module pattern_shift_reg #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] DEF_PAT = 5'b11011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             reload,
  input  logic             shift,
  output logic             sdo
);

  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-1:0] sh;
  logic [PAT_W-1:0] src;

  // A load in the same cycle as a reload feeds the new pattern straight through.
  assign src = load ? pattern_in : pat_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_reg <= DEF_PAT;
      sh      <= '0;
      sdo     <= 1'b0;
    end else begin
      if (load) pat_reg <= pattern_in;
      if (reload) begin
        sdo <= src[PAT_W-1];
        sh  <= {src[PAT_W-2:0], 1'b0};
      end else if (shift) begin
        sdo <= sh[PAT_W-1];
        sh  <= {sh[PAT_W-2:0], 1'b0};
      end else begin
        sdo <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: repeats a stored pattern MSB-first with optional idle gaps.
//   state | meaning
//   IDLE  | waiting for start; pattern may be loaded
//   SEND  | shifting pattern bits, idx = bit on x
//   GAP   | idle gap between repeats
//   DONE  | one-cycle completion pulse
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PATTERN),
  parameter int               REP_W   = 4,
  parameter int               GAP_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_pat,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             start,
  input  logic [REP_W-1:0] reps_in,
  input  logic [GAP_W-1:0] gap_in,
  input  logic             stop,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_lat;
  logic [GAP_W-1:0] gap_cnt;
  logic             cont;

  logic start_ok, load_ok, aborting, pat_end, more, reload, shift;

  always_comb begin
    start_ok = (state == ST_IDLE) && start && !stop;
    load_ok  = (state == ST_IDLE) && load_pat;
    aborting = stop && ((state == ST_SEND) || (state == ST_GAP));
    pat_end  = (state == ST_SEND) && (idx == '0);
    more     = cont || (rep_cnt != REP_W'(1));
    reload   = !aborting && (start_ok
                             || (pat_end && more && (gap_lat == '0))
                             || ((state == ST_GAP) && (gap_cnt == '0)));
    shift    = !aborting && (state == ST_SEND) && (idx != '0);
  end

  pattern_shift_reg #(
    .PAT_W  (PAT_W),
    .DEF_PAT(DEF_PAT)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_ok),
    .pattern_in(pattern_in),
    .reload    (reload),
    .shift     (shift),
    .sdo       (x)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      rep_cnt <= '0;
      gap_lat <= '0;
      gap_cnt <= '0;
      cont    <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            rep_cnt <= reps_in;
            cont    <= (reps_in == '0);
            gap_lat <= gap_in;
            idx     <= IDX_MAX;
            state   <= ST_SEND;
            valid   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_SEND: begin
          if (stop) begin
            state <= ST_IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (idx != '0) begin
            idx <= idx - IDX_W'(1);
          end else if (more) begin
            if (!cont) rep_cnt <= rep_cnt - REP_W'(1);
            if (gap_lat != '0) begin
              // Gap counts down to zero inclusive, so preload one less.
              gap_cnt <= gap_lat - GAP_W'(1);
              state   <= ST_GAP;
              valid   <= 1'b0;
            end else begin
              idx <= IDX_MAX;
            end
          end else begin
            state <= ST_DONE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt == '0) begin
            idx   <= IDX_MAX;
            state <= ST_SEND;
            valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: vector table, directed corner cases, random bursts.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load_pat = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] pattern_in = '0;
  logic [3:0] reps_in = '0;
  logic [2:0] gap_in = '0;
  logic       x, valid, busy, done;

  int errors = 0;
  int checks = 0;

  logic [4:0] m_pat;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  seq_pattern_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_pat  (load_pat),
    .pattern_in(pattern_in),
    .start     (start),
    .reps_in   (reps_in),
    .gap_in    (gap_in),
    .stop      (stop),
    .x         (x),
    .valid     (valid),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic        load;
    logic [4:0]  pat;
    logic [3:0]  reps;
    logic [2:0]  gap;
    int          ncyc;
    logic [31:0] exp_x;
    logic [31:0] exp_v;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_pat = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    pattern_in = '0;
    reps_in  = '0;
    gap_in   = '0;
  endtask

  // Expected per-cycle {x,valid,busy,done} for a finite burst, then one idle cycle.
  task automatic model_burst(input logic [4:0] p, input logic [3:0] reps, input logic [2:0] gap);
    for (int r = 0; r < int'(reps); r++) begin
      for (int i = 4; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
      if (r < int'(reps) - 1)
        for (int g = 0; g < int'(gap); g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endtask

  task automatic run_burst(input logic ld, input logic [4:0] p, input logic [3:0] reps,
                           input logic [2:0] gap, input logic wiggle, input string nm);
    logic [3:0] e;
    if (ld) m_pat = p;
    exp_q.delete();
    model_burst(m_pat, reps, gap);
    load_pat = ld; pattern_in = p; reps_in = reps; gap_in = gap; start = 1'b1;
    tick();
    idle_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(nm, {28'b0, x, valid, busy, done}, {28'b0, e});
      if (wiggle && (e[1] || e[0])) begin
        load_pat   = 1'($urandom);
        start      = 1'($urandom);
        pattern_in = 5'($urandom);
        reps_in    = 4'($urandom);
        gap_in     = 3'($urandom);
      end else begin
        idle_inputs();
      end
      tick();
    end
  endtask

  initial begin
    logic [4:0]  dp;
    logic [11:0] cexp;
    logic [11:0] got_x, got_v;
    logic        done_seen;

    vecs[0] = '{1'b0, 5'b00000, 4'd1, 3'd0, 5,  {5'b11011, 27'b0},           {5'b11111, 27'b0}};
    vecs[1] = '{1'b1, 5'b10110, 4'd2, 3'd2, 12, {12'b101100010110, 20'b0},   {12'b111110011111, 20'b0}};
    vecs[2] = '{1'b1, 5'b01001, 4'd3, 3'd0, 15, {15'b010010100101001, 17'b0}, {15'h7fff, 17'b0}};
    vecs[3] = '{1'b1, 5'b10000, 4'd1, 3'd7, 5,  {5'b10000, 27'b0},           {5'b11111, 27'b0}};
    dp   = 5'b11011;
    cexp = 12'b110111101111;
    m_pat = 5'b11011;

    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", {28'b0, x, valid, busy, done}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {28'b0, x, valid, busy, done}, 32'h0);

    // Inputs wiggled while busy and start held through DONE must be ignored.
    reps_in = 4'd1; gap_in = 3'd0; start = 1'b1;
    tick();
    idle_inputs();
    load_pat = 1'b1; pattern_in = 5'b00000; start = 1'b1; reps_in = 4'd5; gap_in = 3'd3;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("busy_ign_x%0d", c), {31'b0, x}, {31'b0, dp[5-c]});
      tick();
    end
    chk("busy_ign_done", {28'b0, x, valid, busy, done}, 32'h1);
    tick();
    idle_inputs();
    chk("done_start_ignored", {28'b0, x, valid, busy, done}, 32'h0);
    tick();
    chk("done_start_ignored2", {28'b0, x, valid, busy, done}, 32'h0);
    run_burst(1'b0, 5'b0, 4'd1, 3'd0, 1'b0, "after_ign_burst");

    // Continuous mode aborted by stop after 12 bits.
    reps_in = 4'd0; gap_in = 3'd0; start = 1'b1;
    tick();
    idle_inputs();
    got_x = '0; got_v = '0; done_seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      got_x = {got_x[10:0], x};
      got_v = {got_v[10:0], valid};
      done_seen = done_seen | done;
      if (c == 12) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("cont_bits", {20'b0, got_x}, {20'b0, cexp});
    chk("cont_valid", {20'b0, got_v}, 32'hfff);
    chk("stop_outputs", {28'b0, x, valid, busy, done}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      done_seen = done_seen | done;
      tick();
    end
    chk("cont_no_done", {31'b0, done_seen}, 32'h0);

    // start and stop together in IDLE: no burst.
    start = 1'b1; stop = 1'b1; reps_in = 4'd1;
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("start_stop_%0d", c), {28'b0, x, valid, busy, done}, 32'h0);
      tick();
    end

    for (int v = 0; v < 4; v++) begin
      load_pat = vecs[v].load; pattern_in = vecs[v].pat;
      reps_in = vecs[v].reps; gap_in = vecs[v].gap; start = 1'b1;
      tick();
      idle_inputs();
      for (int c = 1; c <= vecs[v].ncyc; c++) begin
        chk($sformatf("vec%0d_x%0d", v, c), {31'b0, x}, {31'b0, vecs[v].exp_x[32-c]});
        chk($sformatf("vec%0d_v%0d", v, c), {30'b0, valid, busy}, {30'b0, vecs[v].exp_v[32-c], 1'b1});
        tick();
      end
      chk($sformatf("vec%0d_done", v), {28'b0, x, valid, busy, done}, 32'h1);
      tick();
      chk($sformatf("vec%0d_idle", v), {28'b0, x, valid, busy, done}, 32'h0);
    end

    // Reset mid-burst on the third bit, then the default pattern returns.
    load_pat = 1'b1; pattern_in = 5'b11111; reps_in = 4'd2; gap_in = 3'd1; start = 1'b1;
    tick();
    idle_inputs();
    tick(); tick();
    chk("pre_reset_bit3", {30'b0, valid, busy}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {28'b0, x, valid, busy, done}, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    m_pat = 5'b11011;
    run_burst(1'b0, 5'b0, 4'd1, 3'd0, 1'b0, "post_reset_burst");

    for (int k = 0; k < 25; k++)
      run_burst(1'($urandom), 5'($urandom), 4'($urandom_range(1, 3)),
                3'($urandom_range(0, 3)), 1'b1, $sformatf("rand_burst%0d", k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
